// File: rtl/ex_muldiv_unit_if.sv
// Bundle of the ID/EX-side request signals and the HI/LO/stall results of
// the EX-stage multiply/divide unit. The pipeline drives the master modport,
// the unit implements the slave modport.
//
// Handshake: a request (I_MD_Start with I_MD_Op/A/B) is taken only on a
// rising edge where O_MD_Busy=0 and I_MD_Abort=0; there is no queuing, so a
// request presented while O_MD_Busy=1 is dropped. O_MD_Busy is the stall
// (not-ready) indication. Completion is a single-cycle O_MD_Done pulse in
// the cycle HI/LO first show the new result.
interface ex_muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            I_MD_Start;
  logic [1:0]      I_MD_Op;
  logic [XLEN-1:0] I_MD_A;
  logic [XLEN-1:0] I_MD_B;
  logic            I_MD_WriteHi;
  logic            I_MD_WriteLo;
  logic [XLEN-1:0] I_MD_WData;
  logic            I_MD_Abort;
  logic            O_MD_Busy;
  logic            O_MD_Done;
  logic [XLEN-1:0] O_MD_HI;
  logic [XLEN-1:0] O_MD_LO;
  logic [1:0]      O_MD_DbgState;

  modport master (
    output I_MD_Start, I_MD_Op, I_MD_A, I_MD_B,
    output I_MD_WriteHi, I_MD_WriteLo, I_MD_WData, I_MD_Abort,
    input  O_MD_Busy, O_MD_Done, O_MD_HI, O_MD_LO, O_MD_DbgState
  );

  modport slave (
    input  I_MD_Start, I_MD_Op, I_MD_A, I_MD_B,
    input  I_MD_WriteHi, I_MD_WriteLo, I_MD_WData, I_MD_Abort,
    output O_MD_Busy, O_MD_Done, O_MD_HI, O_MD_LO, O_MD_DbgState
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit for the EX stage. Works on magnitudes
// (one shift-add or restoring-subtract step per cycle, XLEN steps), applies
// sign correction in a final FIX cycle and then commits to HI/LO. Holds the
// architectural HI/LO registers and the MTHI/MTLO write path.
module ex_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  ex_muldiv_unit_if.slave  md
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;

  // Control decoded from the current state and inputs
  logic w_accept;     // take a new operation this edge
  logic w_mtx_ok;     // MTHI/MTLO strobes may write this edge
  logic w_commit;     // write the finished result to HI/LO this edge

  // Latched operation context
  logic [CW-1:0]     r_count;
  logic [1:0]        r_op;
  logic              r_sign_a;
  logic              r_sign_b;
  logic              r_div_zero;
  logic [XLEN-1:0]   r_opnd_b;   // |B| for signed ops, B otherwise
  logic [XLEN-1:0]   r_a_orig;   // original A, returned in HI on divide by zero
  logic [2*XLEN-1:0] r_acc;      // mult: {partial, multiplier}; div: {rem, dividend/quotient}

  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   r_lo;
  logic              r_busy;
  logic              r_done;

  // Operand conditioning at start
  logic              w_op_signed;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [XLEN-1:0]   w_a_abs;
  logic [XLEN-1:0]   w_b_abs;

  // Iteration datapath
  logic              w_is_div;
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_mul_next;
  logic [XLEN:0]     w_rem_sh;
  logic              w_div_ge;
  logic [XLEN-1:0]   w_div_diff;
  logic [2*XLEN-1:0] w_div_next;

  // Sign-corrected results
  logic              w_res_signed;
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0]   w_quot_fix;
  logic [XLEN-1:0]   w_rem_fix;
  logic [XLEN-1:0]   w_res_hi;
  logic [XLEN-1:0]   w_res_lo;

  // Op encoding: bit1 selects divide, bit0 selects unsigned.
  assign w_op_signed = ~md.I_MD_Op[0];
  assign w_a_neg     = w_op_signed & md.I_MD_A[XLEN-1];
  assign w_b_neg     = w_op_signed & md.I_MD_B[XLEN-1];
  assign w_a_abs     = w_a_neg ? (~md.I_MD_A + XLEN'(1)) : md.I_MD_A;
  assign w_b_abs     = w_b_neg ? (~md.I_MD_B + XLEN'(1)) : md.I_MD_B;

  assign w_is_div    = r_op[1];

  // Shift-add: add multiplicand into the upper half when the current
  // multiplier LSB is set, then shift the whole pair right by one.
  assign w_mul_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} +
                       (r_acc[0] ? {1'b0, r_opnd_b} : {(XLEN+1){1'b0}});
  assign w_mul_next  = {w_mul_sum, r_acc[XLEN-1:1]};

  // Restoring divide: shift {rem, dividend} left, trial-subtract the divisor
  // from the widened remainder, keep the difference when it does not borrow.
  assign w_rem_sh    = r_acc[2*XLEN-1:XLEN-1];
  assign w_div_ge    = (w_rem_sh >= {1'b0, r_opnd_b});
  assign w_div_diff  = w_rem_sh[XLEN-1:0] - r_opnd_b;
  assign w_div_next  = {(w_div_ge ? w_div_diff : w_rem_sh[XLEN-1:0]),
                        r_acc[XLEN-2:0], w_div_ge};

  assign w_res_signed = ~r_op[0];
  assign w_prod_fix   = (w_res_signed & (r_sign_a ^ r_sign_b)) ? (~r_acc + (2*XLEN)'(1)) : r_acc;
  assign w_quot_fix   = (w_res_signed & (r_sign_a ^ r_sign_b)) ?
                        (~r_acc[XLEN-1:0] + XLEN'(1)) : r_acc[XLEN-1:0];
  assign w_rem_fix    = (w_res_signed & r_sign_a) ?
                        (~r_acc[2*XLEN-1:XLEN] + XLEN'(1)) : r_acc[2*XLEN-1:XLEN];

  // Final HI/LO selection; divide by zero bypasses the iterative result.
  always_comb begin
    w_res_hi = w_prod_fix[2*XLEN-1:XLEN];
    w_res_lo = w_prod_fix[XLEN-1:0];
    if (w_is_div) begin
      if (r_div_zero) begin
        w_res_hi = r_a_orig;
        w_res_lo = {XLEN{1'b1}};
      end else begin
        w_res_hi = w_rem_fix;
        w_res_lo = w_quot_fix;
      end
    end
  end

  // Next-state and control decode; Abort wins over everything, Start wins
  // over MTHI/MTLO, and a flushed MTHI/MTLO is dropped along with the Start.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_mtx_ok     = 1'b0;
    w_commit     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!md.I_MD_Abort) begin
          if (md.I_MD_Start) begin
            w_accept     = 1'b1;
            w_next_state = S_RUN;
          end else begin
            w_mtx_ok = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (md.I_MD_Abort) begin
          w_next_state = S_IDLE;
        end else if (r_count == CW'(XLEN-1)) begin
          w_next_state = S_FIX;
        end
      end
      S_FIX: begin
        w_next_state = S_IDLE;
        w_commit     = ~md.I_MD_Abort;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Operation context, iteration datapath and the registered Busy/Done flags
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_count    <= '0;
      r_op       <= '0;
      r_sign_a   <= 1'b0;
      r_sign_b   <= 1'b0;
      r_div_zero <= 1'b0;
      r_opnd_b   <= '0;
      r_a_orig   <= '0;
      r_acc      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_busy <= (w_next_state != S_IDLE);
      r_done <= w_commit;
      if (w_accept) begin
        r_op       <= md.I_MD_Op;
        r_sign_a   <= w_a_neg;
        r_sign_b   <= w_b_neg;
        r_div_zero <= (md.I_MD_B == '0);
        r_opnd_b   <= w_b_abs;
        r_a_orig   <= md.I_MD_A;
        r_count    <= '0;
        // Multiply iterates over the multiplier |A|; divide over the dividend |A|.
        r_acc      <= {{XLEN{1'b0}}, w_a_abs};
      end else if (r_state == S_RUN) begin
        r_acc   <= w_is_div ? w_div_next : w_mul_next;
        r_count <= r_count + CW'(1);
      end
    end
  end

  // Architectural HI/LO: op results on commit, otherwise MTHI/MTLO in IDLE
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_commit) begin
      r_hi <= w_res_hi;
      r_lo <= w_res_lo;
    end else if (w_mtx_ok) begin
      if (md.I_MD_WriteHi) r_hi <= md.I_MD_WData;
      if (md.I_MD_WriteLo) r_lo <= md.I_MD_WData;
    end
  end

  assign md.O_MD_Busy     = r_busy;
  assign md.O_MD_Done     = r_done;
  assign md.O_MD_HI       = r_hi;
  assign md.O_MD_LO       = r_lo;
  assign md.O_MD_DbgState = r_state;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit: directed operations with hand-computed HI/LO,
// plus a transaction-level reference (arithmetic on 64-bit integers and a
// queue of pending results) compared against the outputs every cycle.
module tb_ex_muldiv_unit;

  localparam int XLEN = 32;
  localparam int LAT  = XLEN + 1;   // Busy cycles per operation

  logic CLK;
  logic RESET;
  int   n_checks;
  int   n_fail;
  logic chk_en;

  ex_muldiv_unit_if #(.XLEN(XLEN)) md_if ();

  ex_muldiv_unit #(.XLEN(XLEN)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .md    (md_if)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- reference model ----------------
  logic [2*XLEN-1:0] exp_q[$];   // {hi, lo} of the accepted operation
  logic              m_busy = 1'b0;
  logic              m_done = 1'b0;
  logic [XLEN-1:0]   m_hi   = '0;
  logic [XLEN-1:0]   m_lo   = '0;
  int                m_left = 0;

  function automatic logic [2*XLEN-1:0] md_ref(input logic [1:0] op,
                                                input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
    longint      sa;
    longint      sb;
    logic [63:0] q;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'b00: return 64'(sa * sb);
      2'b01: return {32'b0, a} * {32'b0, b};
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (op == 2'b10) begin
          q = 64'(sa / sb);
          r = 64'(sa % sb);
        end else begin
          q = {32'b0, a / b};
          r = {32'b0, a % b};
        end
        return {r[31:0], q[31:0]};
      end
    endcase
  endfunction

  always @(posedge CLK or posedge RESET) begin
    logic [2*XLEN-1:0] res;
    if (RESET) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_hi   = '0;
      m_lo   = '0;
      m_left = 0;
      exp_q.delete();
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        if (md_if.I_MD_Abort) begin
          m_busy = 1'b0;
          exp_q.delete();
        end else begin
          m_left = m_left - 1;
          if (m_left == 0) begin
            res    = exp_q.pop_front();
            m_busy = 1'b0;
            m_done = 1'b1;
            m_hi   = res[63:32];
            m_lo   = res[31:0];
          end
        end
      end else if (!md_if.I_MD_Abort) begin
        if (md_if.I_MD_Start) begin
          exp_q.push_back(md_ref(md_if.I_MD_Op, md_if.I_MD_A, md_if.I_MD_B));
          m_busy = 1'b1;
          m_left = LAT;
        end else begin
          if (md_if.I_MD_WriteHi) m_hi = md_if.I_MD_WData;
          if (md_if.I_MD_WriteLo) m_lo = md_if.I_MD_WData;
        end
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [XLEN-1:0] act,
                       input logic [XLEN-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the reference model
  always @(negedge CLK) begin
    if (chk_en) begin
      check("cyc_busy", {31'b0, md_if.O_MD_Busy}, {31'b0, m_busy});
      check("cyc_done", {31'b0, md_if.O_MD_Done}, {31'b0, m_done});
      check("cyc_hi",   md_if.O_MD_HI, m_hi);
      check("cyc_lo",   md_if.O_MD_LO, m_lo);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic drive_idle();
    md_if.I_MD_Start   = 1'b0;
    md_if.I_MD_Op      = 2'b00;
    md_if.I_MD_A       = '0;
    md_if.I_MD_B       = '0;
    md_if.I_MD_WriteHi = 1'b0;
    md_if.I_MD_WriteLo = 1'b0;
    md_if.I_MD_WData   = '0;
    md_if.I_MD_Abort   = 1'b0;
  endtask

  // Presents a start for one edge; returns in the first cycle after it.
  task automatic start_op(input logic [1:0] op, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b);
    @(negedge CLK);
    md_if.I_MD_Start = 1'b1;
    md_if.I_MD_Op    = op;
    md_if.I_MD_A     = a;
    md_if.I_MD_B     = b;
    @(negedge CLK);
    drive_idle();
  endtask

  // Counts Busy cycles from the current one (bounded), then checks the
  // completion cycle against literal values.
  task automatic wait_done(input string name, input int exp_busy,
                           input logic [XLEN-1:0] exp_hi,
                           input logic [XLEN-1:0] exp_lo);
    int nb;
    nb = 0;
    while (md_if.O_MD_Busy && nb < 200) begin
      nb++;
      @(negedge CLK);
    end
    check({name, "_busy_cycles"}, XLEN'(nb), XLEN'(exp_busy));
    check({name, "_done"}, {31'b0, md_if.O_MD_Done}, 32'd1);
    check({name, "_hi"}, md_if.O_MD_HI, exp_hi);
    check({name, "_lo"}, md_if.O_MD_LO, exp_lo);
    @(negedge CLK);
    check({name, "_done_drop"}, {31'b0, md_if.O_MD_Done}, 32'd0);
  endtask

  task automatic run_op(input string name, input logic [1:0] op,
                        input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [XLEN-1:0] exp_hi, input logic [XLEN-1:0] exp_lo);
    start_op(op, a, b);
    wait_done(name, LAT, exp_hi, exp_lo);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    chk_en   = 1'b0;
    RESET    = 1'b0;
    drive_idle();
    #3 RESET = 1'b1;
    #20 RESET = 1'b0;
    chk_en = 1'b1;
    @(negedge CLK);

    // Reset state
    check("rst_busy", {31'b0, md_if.O_MD_Busy}, 32'd0);
    check("rst_done", {31'b0, md_if.O_MD_Done}, 32'd0);
    check("rst_hi", md_if.O_MD_HI, 32'd0);
    check("rst_lo", md_if.O_MD_LO, 32'd0);

    // MTHI / MTLO in IDLE
    md_if.I_MD_WriteHi = 1'b1;
    md_if.I_MD_WData   = 32'h1234_5678;
    @(negedge CLK);
    drive_idle();
    check("mthi", md_if.O_MD_HI, 32'h1234_5678);
    check("mthi_lo_kept", md_if.O_MD_LO, 32'd0);
    md_if.I_MD_WriteLo = 1'b1;
    md_if.I_MD_WData   = 32'hCAFE_F00D;
    @(negedge CLK);
    drive_idle();
    check("mtlo", md_if.O_MD_LO, 32'hCAFE_F00D);

    // Directed operations with hand-computed results
    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult_neg",  2'b00, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("mult_ext",  2'b00, 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000);
    run_op("div_neg",   2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_negb",  2'b10, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
    run_op("divu_zero", 2'b11, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF);
    run_op("div_zero",  2'b10, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF);
    run_op("div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000);
    run_op("divu_big",  2'b11, 32'hFFFF_FFFF, 32'd16,        32'd15,        32'h0FFF_FFFF);

    // MTHI together with Start: write dropped, op proceeds (HI was 15)
    @(negedge CLK);
    md_if.I_MD_Start   = 1'b1;
    md_if.I_MD_Op      = 2'b01;
    md_if.I_MD_A       = 32'd6;
    md_if.I_MD_B       = 32'd7;
    md_if.I_MD_WriteHi = 1'b1;
    md_if.I_MD_WData   = 32'hDEAD_BEEF;
    @(negedge CLK);
    drive_idle();
    check("mthi_with_start_hi", md_if.O_MD_HI, 32'd15);
    wait_done("mthi_with_start", LAT, 32'd0, 32'd42);

    // Abort mid-RUN: HI/LO keep 0/42, no Done (watched by the per-cycle compare)
    start_op(2'b11, 32'd9, 32'd2);
    cyc(4);
    md_if.I_MD_Abort = 1'b1;
    @(negedge CLK);
    drive_idle();
    check("abort_busy", {31'b0, md_if.O_MD_Busy}, 32'd0);
    check("abort_hi", md_if.O_MD_HI, 32'd0);
    check("abort_lo", md_if.O_MD_LO, 32'd42);
    cyc(40);

    // Abort in IDLE beats Start
    @(negedge CLK);
    md_if.I_MD_Start = 1'b1;
    md_if.I_MD_Op    = 2'b01;
    md_if.I_MD_A     = 32'd2;
    md_if.I_MD_B     = 32'd2;
    md_if.I_MD_Abort = 1'b1;
    @(negedge CLK);
    drive_idle();
    check("abort_idle_busy", {31'b0, md_if.O_MD_Busy}, 32'd0);
    cyc(3);
    check("abort_idle_lo", md_if.O_MD_LO, 32'd42);

    // Start while Busy is ignored: the original DIVU 9/2 completes on time
    start_op(2'b11, 32'd9, 32'd2);
    md_if.I_MD_Start   = 1'b1;
    md_if.I_MD_Op      = 2'b01;
    md_if.I_MD_A       = 32'd3;
    md_if.I_MD_B       = 32'd3;
    md_if.I_MD_WriteHi = 1'b1;
    md_if.I_MD_WData   = 32'h5555_AAAA;
    @(negedge CLK);
    drive_idle();
    wait_done("busy_start_ignored", LAT - 1, 32'd1, 32'd4);

    // Asynchronous reset mid-RUN (count at 10): immediate clear, no Done
    start_op(2'b01, 32'd5, 32'd5);
    cyc(10);
    #2 RESET = 1'b1;
    #1;
    check("midrst_busy", {31'b0, md_if.O_MD_Busy}, 32'd0);
    check("midrst_done", {31'b0, md_if.O_MD_Done}, 32'd0);
    check("midrst_hi", md_if.O_MD_HI, 32'd0);
    check("midrst_lo", md_if.O_MD_LO, 32'd0);
    #4 RESET = 1'b0;
    cyc(40);

    // Unit still works after the reset
    run_op("post_rst", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global time bound so the run always ends
  initial begin
    #200000;
    n_fail++;
    $display("FAIL timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
